// File: rtl/imem_access_ctrl.sv
// Single-port instruction memory sequencer shared by the core fetch unit
// and the program loader, with boot/halt states and a starvation guard.
module imem_access_ctrl #(
   parameter int unsigned DEPTH        = 25,
   parameter int unsigned AW           = 5,
   parameter int unsigned DW           = 32,
   parameter bit          BOOT_EN      = 1'b1,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          f_req,
   input  logic [AW-1:0] f_addr,
   output logic          f_gnt,
   output logic          f_rvalid,
   output logic          f_err,
   input  logic          l_req,
   input  logic          l_we,
   input  logic [AW-1:0] l_addr,
   input  logic [DW-1:0] l_wdata,
   output logic          l_gnt,
   output logic          l_rvalid,
   output logic          l_err,
   input  logic          load_done,
   input  logic          halt_req,
   output logic [DW-1:0] rdata,
   output logic [AW-1:0] mem_addr,
   output logic          mem_mode,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic [1:0]    state
);

   localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] LIM = SW'(STARVE_LIMIT);
   localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

   typedef enum logic [1:0] {
      BOOT = 2'b00,
      RUN  = 2'b01,
      HALT = 2'b10
   } state_e;

   state_e        state_q, state_d;
   logic [SW-1:0] starve_q, starve_d;
   logic [AW-1:0] addr_q, addr_d;
   logic          f_rvalid_q, f_rvalid_d;
   logic          l_rvalid_q, l_rvalid_d;
   logic          err_q, err_d;
   logic          zero_q, zero_d;
   logic          f_acc, l_acc;
   logic          f_oor, l_oor;

   assign f_oor = {1'b0, f_addr} >= DEPTH_W;
   assign l_oor = {1'b0, l_addr} >= DEPTH_W;

   // Grants are combinational; nothing is accepted while reset is held.
   always_comb begin
      f_acc = 1'b0;
      l_acc = 1'b0;
      if (!rst) begin
         unique case (state_q)
            RUN: begin
               if (l_req && starve_q == LIM) l_acc = 1'b1;
               else if (f_req)              f_acc = 1'b1;
               else                         l_acc = l_req;
            end
            default: l_acc = l_req;
         endcase
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         BOOT:    if (load_done) state_d = RUN;
         RUN:     if (halt_req)  state_d = HALT;
         HALT:    if (!halt_req) state_d = RUN;
         default: state_d = BOOT_EN ? BOOT : RUN;
      endcase
   end

   always_comb begin
      starve_d = '0;
      if (state_q == RUN && l_req && !l_acc) begin
         starve_d = (starve_q == LIM) ? starve_q : starve_q + SW'(1);
      end
   end

   always_comb begin
      addr_d = addr_q;
      if (f_acc)      addr_d = f_addr;
      else if (l_acc) addr_d = l_addr;
      f_rvalid_d = f_acc;
      l_rvalid_d = l_acc;
      err_d      = f_acc ? f_oor : (l_acc & l_oor);
      zero_d     = err_d | (l_acc & l_we);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= BOOT_EN ? BOOT : RUN;
         starve_q   <= '0;
         addr_q     <= '0;
         f_rvalid_q <= 1'b0;
         l_rvalid_q <= 1'b0;
         err_q      <= 1'b0;
         zero_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         starve_q   <= starve_d;
         addr_q     <= addr_d;
         f_rvalid_q <= f_rvalid_d;
         l_rvalid_q <= l_rvalid_d;
         err_q      <= err_d;
         zero_q     <= zero_d;
      end
   end

   assign f_gnt     = f_acc;
   assign l_gnt     = l_acc;
   assign f_rvalid  = f_rvalid_q;
   assign l_rvalid  = l_rvalid_q;
   assign f_err     = f_rvalid_q & err_q;
   assign l_err     = l_rvalid_q & err_q;
   assign state     = state_q;
   // Out-of-range addresses never turn into a write strobe.
   assign mem_mode  = ~(l_acc & l_we & ~l_oor);
   assign mem_addr  = rst ? '0 : addr_d;
   assign mem_wdata = rst ? '0 : l_wdata;
   assign rdata     = ((f_rvalid_q | l_rvalid_q) & ~zero_q) ? mem_rdata : '0;

endmodule
